// File: rtl/data_island_scheduler_pkg.sv
// rtl/data_island_scheduler_pkg.sv - shared video mode type, island timing constants and island sizing
package data_island_scheduler_pkg;

    typedef struct packed {
        logic [11:0] h_active;
        logic [11:0] h_total;
        logic [11:0] v_active;
    } video_mode_t;

    localparam int PACKET_LEN        = 32;
    localparam int ISLAND_OVERHEAD   = 30;
    localparam int PREAMBLE_OFFSET   = 4;
    localparam int LEAD_GUARD_OFFSET = 12;
    localparam int PACKET_OFFSET     = 14;
    localparam int GUARD_LEN         = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_LEAD_GUARD,
        ST_ISLAND,
        ST_TRAIL_GUARD
    } island_state_t;

    // Packets that fit in the horizontal blanking after the fixed overhead, clamped at zero and at the cap.
    function automatic logic [4:0] calc_packets_per_line(
        input logic [11:0] h_active,
        input logic [11:0] h_total,
        input int          max_packets
    );
        logic [12:0] blank;
        logic [12:0] raw;
        blank = {1'b0, h_total} - {1'b0, h_active};
        if ({1'b0, h_total} < {1'b0, h_active} + 13'(ISLAND_OVERHEAD)) begin
            raw = '0;
        end else begin
            raw = (blank - 13'(ISLAND_OVERHEAD)) / 13'(PACKET_LEN);
        end
        if (raw > 13'(max_packets)) begin
            return 5'(max_packets);
        end
        return raw[4:0];
    endfunction

endpackage

// File: rtl/data_island_scheduler_arbiter.sv
// rtl/data_island_scheduler_arbiter.sv - fixed-priority packet slot arbiter with per-frame sent flags
module island_slot_arbiter
    import data_island_scheduler_pkg::*;
#(
    parameter int                   NUM_SLOTS        = 4,
    parameter logic [NUM_SLOTS-1:0] FRAME_SLOTS_MASK = 4'b0110
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         evaluate,
    input  logic                         rearm,
    input  logic [NUM_SLOTS-1:0]         pkt_req,
    output logic [NUM_SLOTS-1:0]         pkt_grant,
    output logic [$clog2(NUM_SLOTS)-1:0] packet_index
);

    localparam int IDX_W = $clog2(NUM_SLOTS);

    logic [NUM_SLOTS-1:0] sent;
    logic [NUM_SLOTS-1:0] eligible;
    logic [NUM_SLOTS-1:0] winner_onehot;
    logic [IDX_W-1:0]     winner;
    logic                 found;

    // Slot 0 is the null packet: never eligible, it wins only by default.
    always_comb begin
        eligible = ((FRAME_SLOTS_MASK & ~sent) | pkt_req) & ~NUM_SLOTS'(1);
        winner   = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (eligible[i] && !found) begin
                winner = IDX_W'(i);
                found  = 1'b1;
            end
        end
        winner_onehot = NUM_SLOTS'(1) << winner;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sent         <= '0;
            pkt_grant    <= '0;
            packet_index <= '0;
        end else begin
            pkt_grant <= evaluate ? winner_onehot : '0;
            if (evaluate) begin
                packet_index <= winner;
            end
            if (rearm) begin
                sent <= sent & ~FRAME_SLOTS_MASK;
            end else if (evaluate) begin
                sent <= sent | (winner_onehot & FRAME_SLOTS_MASK);
            end
        end
    end

endmodule

// File: rtl/data_island_scheduler.sv
// rtl/data_island_scheduler.sv - per-line data island window sequencer and packet slot scheduler
module data_island_scheduler
    import data_island_scheduler_pkg::*;
#(
    parameter int                   NUM_SLOTS            = 4,
    parameter logic [NUM_SLOTS-1:0] FRAME_SLOTS_MASK     = 4'b0110,
    parameter int                   MAX_PACKETS_PER_LINE = 18
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  video_mode_t                  videoMode,
    input  logic [11:0]                  counterX,
    input  logic [11:0]                  counterY,
    input  logic [NUM_SLOTS-1:0]         pkt_req,
    output logic [NUM_SLOTS-1:0]         pkt_grant,
    output logic [$clog2(NUM_SLOTS)-1:0] packet_index,
    output logic                         packet_enable,
    output logic                         data_preamble,
    output logic                         data_guard,
    output logic                         data_period,
    output logic [4:0]                   packets_per_line
);

    localparam logic [4:0] PREAMBLE_LAST = 5'(LEAD_GUARD_OFFSET - PREAMBLE_OFFSET - 1);
    localparam logic [4:0] LEAD_LAST     = 5'(PACKET_OFFSET - LEAD_GUARD_OFFSET - 1);
    localparam logic [4:0] GUARD_LAST    = 5'(GUARD_LEN - 1);
    localparam logic [4:0] PACKET_LAST   = 5'(PACKET_LEN - 1);

    island_state_t state, state_next;
    logic [4:0]    pix_cnt, pix_next;
    logic [4:0]    pkt_cnt, pkt_next;
    logic [11:0]   prev_x;
    logic          x_jump;
    logic          island_start;
    logic          packet_start;
    logic          frame_end;

    // Any column step other than +1 (or a wrap to 0) means the timing source jumped; abandon the island.
    assign x_jump       = (counterX != prev_x + 12'd1) && (counterX != 12'd0);
    assign island_start = ({1'b0, counterX} == {1'b0, videoMode.h_active} + 13'(PREAMBLE_OFFSET))
                          && (packets_per_line != 5'd0);
    assign frame_end    = (counterX == videoMode.h_active - 12'd1)
                          && (counterY == videoMode.v_active - 12'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            pix_cnt          <= '0;
            pkt_cnt          <= '0;
            prev_x           <= '0;
            packets_per_line <= '0;
            data_preamble    <= 1'b0;
            data_guard       <= 1'b0;
            data_period      <= 1'b0;
            packet_enable    <= 1'b0;
        end else begin
            state            <= state_next;
            pix_cnt          <= pix_next;
            pkt_cnt          <= pkt_next;
            prev_x           <= counterX;
            packets_per_line <= calc_packets_per_line(videoMode.h_active, videoMode.h_total,
                                                      MAX_PACKETS_PER_LINE);
            data_preamble    <= (state_next == ST_PREAMBLE);
            data_guard       <= (state_next == ST_LEAD_GUARD) || (state_next == ST_TRAIL_GUARD);
            data_period      <= (state_next == ST_ISLAND);
            packet_enable    <= packet_start;
        end
    end

    always_comb begin
        state_next   = state;
        pix_next     = pix_cnt + 5'd1;
        pkt_next     = pkt_cnt;
        packet_start = 1'b0;
        unique case (state)
            ST_IDLE: begin
                pix_next = '0;
                pkt_next = '0;
                if (island_start) begin
                    state_next = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (pix_cnt == PREAMBLE_LAST) begin
                    state_next = ST_LEAD_GUARD;
                    pix_next   = '0;
                end
            end
            ST_LEAD_GUARD: begin
                if (pix_cnt == LEAD_LAST) begin
                    state_next = ST_ISLAND;
                    pix_next   = '0;
                end
            end
            ST_ISLAND: begin
                // pix_cnt wraps to 0 on its own at each packet boundary.
                if (pix_cnt == PACKET_LAST) begin
                    pkt_next = pkt_cnt + 5'd1;
                    if (pkt_cnt == packets_per_line - 5'd1) begin
                        state_next = ST_TRAIL_GUARD;
                        pkt_next   = '0;
                    end
                end
            end
            ST_TRAIL_GUARD: begin
                if (pix_cnt == GUARD_LAST) begin
                    state_next = ST_IDLE;
                    pix_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                pix_next   = '0;
                pkt_next   = '0;
            end
        endcase
        if (x_jump) begin
            state_next = ST_IDLE;
            pix_next   = '0;
            pkt_next   = '0;
        end
        packet_start = (state_next == ST_ISLAND) && (pix_next == 5'd0);
    end

    island_slot_arbiter #(
        .NUM_SLOTS        (NUM_SLOTS),
        .FRAME_SLOTS_MASK (FRAME_SLOTS_MASK)
    ) u_arbiter (
        .clock        (clock),
        .reset_n      (reset_n),
        .evaluate     (packet_start),
        .rearm        (frame_end),
        .pkt_req      (pkt_req),
        .pkt_grant    (pkt_grant),
        .packet_index (packet_index)
    );

endmodule

// File: tb/tb_data_island_scheduler.sv
// tb/tb_data_island_scheduler.sv - randomized scoreboard bench for data_island_scheduler
module tb_data_island_scheduler;
    import data_island_scheduler_pkg::*;

    localparam int         NS         = 4;
    localparam logic [3:0] FRAME_MASK = 4'b0110;
    localparam int         MAXP       = 18;
    localparam int REQ_NONE = 0, REQ_DROP = 1, REQ_HOLD = 2, REQ_RANDOM = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    video_mode_t   videoMode;
    logic [11:0]   counterX;
    logic [11:0]   counterY;
    logic [NS-1:0] pkt_req;
    logic [NS-1:0] pkt_grant;
    logic [1:0]    packet_index;
    logic          packet_enable;
    logic          data_preamble;
    logic          data_guard;
    logic          data_period;
    logic [4:0]    packets_per_line;

    always #5 clock = ~clock;

    data_island_scheduler #(
        .NUM_SLOTS            (NS),
        .FRAME_SLOTS_MASK     (FRAME_MASK),
        .MAX_PACKETS_PER_LINE (MAXP)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .videoMode        (videoMode),
        .counterX         (counterX),
        .counterY         (counterY),
        .pkt_req          (pkt_req),
        .pkt_grant        (pkt_grant),
        .packet_index     (packet_index),
        .packet_enable    (packet_enable),
        .data_preamble    (data_preamble),
        .data_guard       (data_guard),
        .data_period      (data_period),
        .packets_per_line (packets_per_line)
    );

    typedef struct packed {
        logic       pre;
        logic       guard;
        logic       period;
        logic       pen;
        logic [4:0] ppl;
        logic [3:0] grant;
        logic [1:0] index;
    } obs_t;

    obs_t        sb_q[$];
    obs_t        pending;
    obs_t        mon_e;
    bit          pending_valid;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          pen_seen = 0;
    int          g3_seen = 0;
    int          base;
    logic [3:0]  sent_m;
    int          idx_m;
    bit          live_m;
    int          req_mode;
    int          drop_col;
    video_mode_t line_mode;

    function automatic obs_t observe();
        return {data_preamble, data_guard, data_period, packet_enable,
                packets_per_line, pkt_grant, packet_index};
    endfunction

    function automatic video_mode_t mk_mode(input int ha, input int ht, input int va);
        video_mode_t m;
        m.h_active = 12'(ha);
        m.h_total  = 12'(ht);
        m.v_active = 12'(va);
        return m;
    endfunction

    function automatic int model_n(input int ha, input int ht);
        int fit;
        if (ht - ha < 30) return 0;
        fit = (ht - ha - 30) / 32;
        return (fit > MAXP) ? MAXP : fit;
    endfunction

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t x=%0d)", what, act, exp, $time, counterX);
        end
    endtask

    // Expected outputs for the cycle after column c is presented, from the island window rules.
    task automatic model_step(input int c, input int y);
        obs_t e;
        int   h, n, w;
        e = '0;
        if (!reset_n) begin
            live_m = 0;
            sent_m = '0;
            idx_m  = 0;
        end else begin
            h     = int'(videoMode.h_active);
            n     = model_n(h, int'(videoMode.h_total));
            e.ppl = 5'(n);
            if (c == h + 4 && n > 0) live_m = 1;
            if (live_m) begin
                e.pre    = (c >= h + 4 && c <= h + 11);
                e.guard  = (c >= h + 12 && c <= h + 13) || (c >= h + 14 + 32*n && c <= h + 15 + 32*n);
                e.period = (c >= h + 14 && c < h + 14 + 32*n);
                e.pen    = e.period && ((c - h - 14) % 32 == 0);
            end
            if (e.pen) begin
                w = 0;
                for (int i = NS - 1; i >= 1; i--) begin
                    if ((FRAME_MASK[i] && !sent_m[i]) || pkt_req[i]) w = i;
                end
                if (FRAME_MASK[w]) sent_m[w] = 1'b1;
                idx_m   = w;
                e.grant = 4'(1 << w);
                if (w == 3 && req_mode == REQ_DROP) drop_col = c + 2;
            end
            if (c == h + 15 + 32*n) live_m = 0;
            if (c == h - 1 && y == int'(videoMode.v_active) - 1) sent_m = sent_m & ~FRAME_MASK;
        end
        e.index       = 2'(idx_m);
        pending       = e;
        pending_valid = 1;
    endtask

    task automatic run_line(input int y, input int rst_col);
        for (int c = 0; c < int'(line_mode.h_total); c++) begin
            @(posedge clock);
            if (pending_valid) sb_q.push_back(pending);
            #1;
            if (c == 0) videoMode = line_mode;
            counterX = 12'(c);
            counterY = 12'(y);
            if (req_mode == REQ_DROP && c == drop_col) pkt_req[3] = 1'b0;
            if (req_mode == REQ_RANDOM && $urandom_range(63) == 0) pkt_req[$urandom_range(NS - 1)] ^= 1'b1;
            if (c == rst_col) begin
                reset_n = 1'b0;
                #1;
                check("async_reset_outputs", 32'(observe()), 32'h0);
                sb_q[sb_q.size() - 1] = '0;
            end
            if (rst_col >= 0 && c == rst_col + 3) reset_n = 1'b1;
            model_step(c, y);
        end
    endtask

    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("cycle_outputs", 32'(observe()), 32'(mon_e));
        end
        if (packet_enable) pen_seen++;
        if (pkt_grant[3]) g3_seen++;
    end

    initial begin
        reset_n       = 1'b0;
        counterX      = '0;
        counterY      = '0;
        pkt_req       = '0;
        line_mode     = mk_mode(640, 800, 2);
        videoMode     = line_mode;
        req_mode      = REQ_NONE;
        drop_col      = -1;
        sent_m        = '0;
        idx_m         = 0;
        live_m        = 0;
        pending_valid = 0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", 32'(observe()), 32'h0);
        reset_n = 1'b1;

        for (int y = 0; y < 3; y++) run_line(y, -1);
        check("ppl_640x480", 32'(packets_per_line), 32'd4);

        line_mode = mk_mode(1280, 1650, 1);
        run_line(0, -1);
        run_line(1, -1);
        run_line(2, -1);
        run_line(0, -1);
        check("ppl_1280x720", 32'(packets_per_line), 32'd10);

        req_mode = REQ_DROP;
        pkt_req  = 4'b1000;
        base     = g3_seen;
        run_line(0, -1);
        run_line(1, -1);
        check("slot3_grants_dropped", 32'(g3_seen - base), 32'd1);

        req_mode   = REQ_HOLD;
        drop_col   = -1;
        pkt_req[3] = 1'b1;
        base       = g3_seen;
        run_line(1, -1);
        run_line(2, -1);
        check("slot3_grants_held", 32'(g3_seen - base), 32'd20);

        req_mode  = REQ_RANDOM;
        pkt_req   = 4'($urandom);
        line_mode = mk_mode(640, 800, 2);
        for (int y = 0; y < 4; y++) run_line(y, -1);

        req_mode  = REQ_NONE;
        pkt_req   = '0;
        line_mode = mk_mode(640, 660, 1);
        base      = pen_seen;
        run_line(0, -1);
        run_line(1, -1);
        check("ppl_narrow_blank", 32'(packets_per_line), 32'd0);
        check("no_packets_narrow", 32'(pen_seen - base), 32'd0);

        line_mode = mk_mode(640, 800, 1);
        run_line(0, 740);
        run_line(1, -1);
        run_line(2, -1);
        check("ppl_after_reset", 32'(packets_per_line), 32'd4);

        line_mode = mk_mode(1280, 2280, 1);
        run_line(0, -1);
        run_line(1, -1);
        check("ppl_capped", 32'(packets_per_line), 32'd18);

        @(posedge clock);
        if (pending_valid) sb_q.push_back(pending);
        @(negedge clock);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
